// File: rtl/jesd204_rx_link_supervisor_if.sv
// rtl/jesd204_rx_link_supervisor_if.sv - config, link-controller and status bundle for the RX link supervisor
// Ports (slave = supervisor side):
//   cfg_enable, cfg_sync_timeout, cfg_lanes_disable   software configuration
//   link_status_state, lane_err                        RX link controller observation
//   link_reset                                         reset driven into the RX link controller
//   link_failed, resync_event, retry_count,
//   resync_total, status_state                         supervisor status and counters
interface jesd204_rx_link_supervisor_if #(
  parameter int NUM_LANES     = 1,
  parameter int TIMEOUT_WIDTH = 16
);
  logic                     cfg_enable;
  logic [TIMEOUT_WIDTH-1:0] cfg_sync_timeout;
  logic [NUM_LANES-1:0]     cfg_lanes_disable;
  logic [1:0]               link_status_state;
  logic [NUM_LANES-1:0]     lane_err;
  logic                     link_reset;
  logic                     link_failed;
  logic                     resync_event;
  logic [3:0]               retry_count;
  logic [15:0]              resync_total;
  logic [2:0]               status_state;

  modport master (
    output cfg_enable, cfg_sync_timeout, cfg_lanes_disable, link_status_state, lane_err,
    input  link_reset, link_failed, resync_event, retry_count, resync_total, status_state
  );

  modport slave (
    input  cfg_enable, cfg_sync_timeout, cfg_lanes_disable, link_status_state, lane_err,
    output link_reset, link_failed, resync_event, retry_count, resync_total, status_state
  );
endinterface

// File: rtl/jesd204_rx_link_supervisor.sv
// rtl/jesd204_rx_link_supervisor.sv - autonomous bring-up, watchdog and retry sequencer for a JESD204 RX link
// Ports:
//   clk    link clock
//   reset  synchronous, active-high
//   bus    jesd204_rx_link_supervisor_if.slave (config in, link status in, link_reset/status out)
// Parameters: NUM_LANES monitored lanes, TIMEOUT_WIDTH sync timer width, MAX_RETRIES (1..15)
// consecutive retries before the link is declared failed.
module jesd204_rx_link_supervisor #(
  parameter int NUM_LANES     = 1,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int MAX_RETRIES   = 3
) (
  input logic                         clk,
  input logic                         reset,
  jesd204_rx_link_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOLD_RESET = 3'd1,
    WAIT_SYNC  = 3'd2,
    RUNNING    = 3'd3,
    FAILED     = 3'd4
  } state_t;

  // Hold counter counts 15..0 so the controller sees exactly 16 cycles of reset.
  localparam logic [3:0]  HOLD_LOAD   = 4'd15;
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
  localparam logic [1:0]  LINK_SYNCED = 2'd3;
  localparam logic [15:0] TOTAL_MAX   = 16'hFFFF;

  state_t                   state_q;
  logic [3:0]               hold_q;
  logic [TIMEOUT_WIDTH-1:0] timer_q;
  logic [3:0]               retry_q;
  logic [15:0]              total_q;
  logic                     event_q;

  logic synced;
  logic lane_fault;
  logic retry_req;

  assign synced     = (bus.link_status_state == LINK_SYNCED);
  assign lane_fault = |(bus.lane_err & ~bus.cfg_lanes_disable);

  // Sync is checked first in WAIT_SYNC so a sync landing on the last timer
  // cycle wins over the timeout. Lane errors only count once RUNNING.
  always_comb begin
    retry_req = 1'b0;
    case (state_q)
      WAIT_SYNC: retry_req = !synced && (timer_q == '0);
      RUNNING:   retry_req = !synced || lane_fault;
      default:   retry_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      timer_q <= '0;
      retry_q <= '0;
      total_q <= '0;
      event_q <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (!bus.cfg_enable) begin
        state_q <= IDLE;
        retry_q <= '0;
      end else if (retry_req) begin
        event_q <= 1'b1;
        if (total_q != TOTAL_MAX) begin
          total_q <= total_q + 16'd1;
        end
        if (retry_q == RETRY_LIMIT) begin
          state_q <= FAILED;
        end else begin
          retry_q <= retry_q + 4'd1;
          state_q <= HOLD_RESET;
          hold_q  <= HOLD_LOAD;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= HOLD_RESET;
            hold_q  <= HOLD_LOAD;
          end
          HOLD_RESET: begin
            if (hold_q == 4'd0) begin
              state_q <= WAIT_SYNC;
              timer_q <= bus.cfg_sync_timeout;
            end else begin
              hold_q <= hold_q - 4'd1;
            end
          end
          WAIT_SYNC: begin
            if (synced) begin
              state_q <= RUNNING;
              retry_q <= '0;
            end else begin
              timer_q <= timer_q - TIMEOUT_WIDTH'(1);
            end
          end
          RUNNING: state_q <= RUNNING;
          FAILED:  state_q <= FAILED;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // link_reset is a pure state decode so it tracks the state with no added latency.
  assign bus.link_reset   = (state_q == IDLE) || (state_q == HOLD_RESET) || (state_q == FAILED);
  assign bus.link_failed  = (state_q == FAILED);
  assign bus.resync_event = event_q;
  assign bus.retry_count  = retry_q;
  assign bus.resync_total = total_q;
  assign bus.status_state = state_q;

endmodule

// File: tb/tb_jesd204_rx_link_supervisor.sv
// tb/tb_jesd204_rx_link_supervisor.sv - directed and randomized self-checking bench for jesd204_rx_link_supervisor
module tb_jesd204_rx_link_supervisor;
  localparam int NL = 4;
  localparam int TW = 16;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic reset;

  jesd204_rx_link_supervisor_if #(.NUM_LANES(NL), .TIMEOUT_WIDTH(TW)) bus ();

  jesd204_rx_link_supervisor #(
    .NUM_LANES(NL), .TIMEOUT_WIDTH(TW), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase uses the documented encodings, elapsed counts
  // completed cycles spent in the current phase.
  int m_phase = 0;
  int m_elapsed = 0;
  int m_tmo = 0;
  int m_retry = 0;
  int m_total = 0;
  bit m_event = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_retry();
    m_event = 1;
    if (m_total < 65535) m_total++;
    if (m_retry == MR) m_phase = 4;
    else begin
      m_retry++;
      m_phase = 1;
      m_elapsed = 0;
    end
  endtask

  task automatic model_step();
    m_event = 0;
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_retry = 0; m_total = 0;
    end else if (!bus.cfg_enable) begin
      m_phase = 0; m_retry = 0;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_elapsed = 0; end
        1: begin
          if (m_elapsed == 15) begin
            m_phase = 2; m_elapsed = 0; m_tmo = int'(bus.cfg_sync_timeout);
          end else m_elapsed++;
        end
        2: begin
          if (bus.link_status_state == 2'd3) begin m_phase = 3; m_retry = 0; end
          else if (m_elapsed == m_tmo) model_retry();
          else m_elapsed++;
        end
        3: begin
          if (bus.link_status_state != 2'd3 || (bus.lane_err & ~bus.cfg_lanes_disable) != '0)
            model_retry();
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("state", bus.status_state, m_phase);
    check("link_reset", bus.link_reset, (m_phase == 0 || m_phase == 1 || m_phase == 4));
    check("link_failed", bus.link_failed, (m_phase == 4));
    check("resync_event", bus.resync_event, m_event);
    check("retry_count", bus.retry_count, m_retry);
    check("resync_total", bus.resync_total, m_total);
  endtask

  initial begin
    int pulses;
    int run;
    int mode;

    reset = 1'b1;
    bus.cfg_enable = 1'b0;
    bus.cfg_sync_timeout = '0;
    bus.cfg_lanes_disable = '0;
    bus.link_status_state = 2'd0;
    bus.lane_err = '0;

    // Reset state
    repeat (3) tick();
    check("rst_state", bus.status_state, 0);
    check("rst_link_reset", bus.link_reset, 1);
    check("rst_total", bus.resync_total, 0);
    reset = 1'b0;
    tick();

    // Clean bring-up: enable sampled at edge 0, sync sampled at edge 20
    bus.cfg_sync_timeout = 16'd10;
    bus.cfg_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("bringup_hold", bus.link_reset, 1);
    end
    tick();
    check("bringup_wait_lr", bus.link_reset, 0);
    check("bringup_wait_st", bus.status_state, 2);
    repeat (3) tick();
    bus.link_status_state = 2'd3;
    tick();
    check("bringup_running", bus.status_state, 3);
    check("bringup_retry", bus.retry_count, 0);
    check("bringup_total", bus.resync_total, 0);

    // Lane error masking
    bus.cfg_sync_timeout = 16'd3;
    bus.cfg_lanes_disable = 4'b0100;
    bus.lane_err = 4'b0100;
    tick();
    bus.lane_err = '0;
    check("mask_state", bus.status_state, 3);
    check("mask_event", bus.resync_event, 0);
    bus.cfg_lanes_disable = '0;
    bus.lane_err = 4'b0100;
    tick();
    bus.lane_err = '0;
    check("lane_event", bus.resync_event, 1);
    check("lane_retry", bus.retry_count, 1);
    check("lane_link_reset", bus.link_reset, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("lane_hold", bus.status_state, 1);
    end
    tick();
    check("lane_wait", bus.status_state, 2);

    // Sync on the same edge the timer expires, then a status drop
    bus.link_status_state = 2'd0;
    repeat (3) tick();
    bus.link_status_state = 2'd3;
    tick();
    check("simul_running", bus.status_state, 3);
    check("simul_event", bus.resync_event, 0);
    check("simul_retry", bus.retry_count, 0);
    bus.link_status_state = 2'd2;
    tick();
    check("drop_event", bus.resync_event, 1);
    check("drop_retry", bus.retry_count, 1);

    // Timeout exhaustion
    bus.cfg_enable = 1'b0;
    tick();
    check("disable_retry", bus.retry_count, 0);
    bus.cfg_sync_timeout = 16'd4;
    bus.link_status_state = 2'd0;
    bus.cfg_enable = 1'b1;
    pulses = 0;
    run = 0;
    for (int i = 0; i < 200 && !bus.link_failed; i++) begin
      tick();
      if (bus.resync_event) pulses++;
      if (bus.status_state == 3'd2) run++;
      else if (run != 0) begin
        check("wait_len", run, 5);
        run = 0;
      end
    end
    check("exhaust_failed", bus.link_failed, 1);
    check("exhaust_pulses", pulses, 4);
    check("exhaust_retry", bus.retry_count, 3);
    check("exhaust_link_reset", bus.link_reset, 1);
    check("exhaust_total", bus.resync_total, 6);

    // Recovery from FAILED
    repeat (3) tick();
    check("failed_hold", bus.status_state, 4);
    bus.cfg_enable = 1'b0;
    tick();
    check("recover_state", bus.status_state, 0);
    check("recover_retry", bus.retry_count, 0);
    check("recover_failed", bus.link_failed, 0);
    check("recover_total", bus.resync_total, 6);
    bus.cfg_enable = 1'b1;
    tick();
    check("reenable_state", bus.status_state, 1);

    // Randomized regimes against the model
    mode = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 50 == 0) mode = int'($urandom_range(0, 2));
      reset = ($urandom_range(0, 499) == 0);
      bus.cfg_enable = ($urandom_range(0, 199) != 0);
      bus.cfg_sync_timeout = 16'($urandom_range(0, 8));
      bus.cfg_lanes_disable = 4'($urandom);
      bus.lane_err = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      case (mode)
        0:       bus.link_status_state = ($urandom_range(0, 99) == 0) ? 2'd2 : 2'd3;
        1:       bus.link_status_state = 2'($urandom_range(0, 2));
        default: bus.link_status_state = 2'($urandom);
      endcase
      tick();
    end

    // resync_total saturation, then reset mid-WAIT_SYNC
    reset = 1'b0;
    bus.lane_err = '0;
    bus.cfg_lanes_disable = '0;
    bus.cfg_enable = 1'b0;
    tick();
    bus.cfg_sync_timeout = 16'd5;
    bus.link_status_state = 2'd3;
    bus.cfg_enable = 1'b1;
    repeat (20) tick();
    check("sat_running", bus.status_state, 3);
    force dut.total_q = 16'hFFFF;
    #1;
    release dut.total_q;
    m_total = 65535;
    bus.link_status_state = 2'd2;
    tick();
    check("sat_event", bus.resync_event, 1);
    check("sat_total", bus.resync_total, 16'hFFFF);
    bus.link_status_state = 2'd0;
    repeat (16) tick();
    check("midwait_state", bus.status_state, 2);
    reset = 1'b1;
    tick();
    check("midrst_state", bus.status_state, 0);
    check("midrst_link_reset", bus.link_reset, 1);
    check("midrst_failed", bus.link_failed, 0);
    check("midrst_event", bus.resync_event, 0);
    check("midrst_retry", bus.retry_count, 0);
    check("midrst_total", bus.resync_total, 0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jesd204_rx_link_supervisor.md
# jesd204_rx_link_supervisor

Supervisory sequencer that sits above the JESD204 RX link controller and owns its reset. It brings the link up and watches for it to reach the synchronized state within a programmable timeout. It tears the link down and retries on a timeout, a loss of sync or a per-lane error, and declares a hard failure after a bounded number of consecutive retries. Software sees only enable, status and counters; all re-initialisation is autonomous.

## Interface
- NUM_LANES, 1: number of lanes whose error strobes are monitored
- TIMEOUT_WIDTH, 16: width of the sync-timeout configuration and timer
- MAX_RETRIES, 3: consecutive retries allowed before FAILED (1..15)

- clk  in  1  link clock
- reset  in  1  synchronous, active-high
- cfg_enable  in  1  supervisor enable; level-sensitive
- cfg_sync_timeout  in  TIMEOUT_WIDTH  cycles allowed in WAIT_SYNC
- cfg_lanes_disable  in  NUM_LANES  1 = ignore that lane's errors
- link_status_state  in  2  RX controller state (0 reset, 1 wait-phy, 2 CGS, 3 synchronized)
- lane_err  in  NUM_LANES  per-lane error strobe, one cycle per error
- link_reset  out  1  reset to the RX link controller
- link_failed  out  1  retries exhausted
- resync_event  out  1  one-cycle pulse per retry decision
- retry_count  out  4  consecutive retries since last successful sync
- resync_total  out  16  lifetime retry decisions, saturating
- status_state  out  3  supervisor state encoding

## Operation
States and encodings:
- IDLE = 0
- HOLD_RESET = 1
- WAIT_SYNC = 2
- RUNNING = 3
- FAILED = 4

Outputs:
- link_reset = 1 in IDLE, HOLD_RESET and FAILED; 0 in WAIT_SYNC and RUNNING.
- link_reset is decoded from the state register, with no extra register stage.
- link_failed = 1 only in FAILED.

Transitions (all evaluated at the clock edge):
- cfg_enable = 0, any state -> IDLE. This has highest priority. IDLE clears retry_count.
- IDLE: cfg_enable = 1 -> HOLD_RESET, with the hold counter loaded to 15.
- HOLD_RESET: hold counter decrements every cycle; when it is 0 -> WAIT_SYNC, with the timer loaded from cfg_sync_timeout.
- WAIT_SYNC, link_status_state == 3 -> RUNNING, and retry_count clears to 0. Sync wins over a timeout in the same cycle.
- WAIT_SYNC, timer == 0 and not synced -> retry decision. Otherwise the timer decrements.
- lane_err is ignored in WAIT_SYNC.
- RUNNING: link_status_state != 3, or any bit of (lane_err & ~cfg_lanes_disable) -> retry decision.
- FAILED: held until cfg_enable = 0.

Retry decision:
- retry_count == MAX_RETRIES -> FAILED, and retry_count holds.
- Otherwise retry_count increments and the state goes to HOLD_RESET (hold counter reloaded to 15).
- Every retry decision, including the one that enters FAILED, raises resync_event and increments resync_total.

Widths and arithmetic:
- resync_total saturates at 0xFFFF and is cleared only by reset.
- retry_count never exceeds MAX_RETRIES.

## Timing
- Reset values: state IDLE, link_reset = 1, link_failed = 0, resync_event = 0, retry_count = 0, resync_total = 0, status_state = 0.
- reset has priority over cfg_enable. Reset mid-operation returns to IDLE on the next edge, with link_reset asserted in that cycle.
- If cfg_enable is first sampled high at edge N: HOLD_RESET occupies cycles N+1..N+16 (exactly 16 cycles of link_reset), and WAIT_SYNC starts at N+17.
- WAIT_SYNC with timeout T lasts exactly T+1 cycles if sync never arrives. T = 0 gives a single WAIT_SYNC cycle.
- A retry decision taken at edge E gives:
  - resync_event high for the cycle after E;
  - the counters updated at E;
  - link_reset high from the cycle after E.
- An error strobe in RUNNING reasserts link_reset one cycle after the strobe is sampled.
- cfg_lanes_disable is sampled every cycle. Changing it mid-RUNNING takes effect immediately.
- cfg_sync_timeout is sampled only on entry to WAIT_SYNC.

## Test plan
- Clean bring-up: enable at edge 0, status 3 driven at cycle 20 -> link_reset low from cycle 17, RUNNING at cycle 21, retry_count = 0, resync_event never pulses.
- Timeout exhaustion: cfg_sync_timeout = 4, MAX_RETRIES = 3, status never 3 -> each WAIT_SYNC lasts 5 cycles. Expect 4 resync_event pulses, retry_count reaching 3, then FAILED with link_failed = 1, link_reset = 1 and resync_total = 4.
- Lane error masking: NUM_LANES = 4, RUNNING, lane_err = 4'b0100:
  - with cfg_lanes_disable = 4'b0100 -> no effect;
  - with cfg_lanes_disable = 0 -> resync_event pulse, retry_count = 1, HOLD_RESET for 16 cycles.
- Simultaneous events: sync arrives in the same cycle the timer hits 0 -> RUNNING and no retry. Then in RUNNING, status drops to 2 -> retry, retry_count = 1.
- Recovery from FAILED: drop cfg_enable -> IDLE with retry_count = 0 and link_failed = 0; resync_total is retained. Re-enable -> bring-up restarts.
- Reset mid-WAIT_SYNC, and resync_total saturation (force 0xFFFF, trigger one more retry) -> all outputs at reset values; the counter holds at 0xFFFF.
